// File: rtl/apb_pkg.sv
// apb_pkg: shared state encoding, default widths and UART console addresses for the APB requester.
package apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int APB_TIMEOUT = 256;
  localparam logic [31:0] UART_DATA_ADDR = 32'h10000000;
  localparam logic [31:0] UART_STAT_ADDR = 32'h10000005;
endpackage

// File: rtl/apb_watchdog.sv
// apb_watchdog: counts stalled ACCESS cycles and flags the one that reaches LIMIT.
module apb_watchdog #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end
  // Fires during the stalled cycle whose end would bring the count to LIMIT.
  assign expired = enable && cnt == W'(LIMIT - 1);
endmodule

// File: rtl/apb_requester.sv
// apb_requester: single-outstanding APB-style initiator between the core data port and peripherals.
// Optional ACCESS-phase timeout is built in when APB_TIMEOUT_EN is defined.
module apb_requester import apb_pkg::*; #(
  parameter int ADDR_WIDTH = APB_ADDR_W,
  parameter int DATA_WIDTH = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  cpu_we,
  input  logic [3:0]            cpu_stb,
  output logic                  cpu_busy,
  output logic                  cpu_done,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pdata,
  output logic                  pwrite,
  output logic [3:0]            pstb,
  output logic                  psel,
  output logic                  penable,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  ready,
  input  logic                  perr
);
  apb_state_t state, state_n;
  logic expired;
  logic fin;
`ifdef APB_TIMEOUT_EN
  apb_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk(pclk),
    .rst(rst),
    .clear(state != ACCESS),
    .enable(state == ACCESS && !ready),
    .expired(expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES != 0;
  assign expired = 1'b0;
`endif
  assign fin = state == ACCESS && (ready || expired);
  always_comb begin
    state_n = state == IDLE ? (cpu_req ? SETUP : IDLE) : state == SETUP ? ACCESS : (fin ? IDLE : ACCESS);
    psel = state != IDLE;
    penable = state == ACCESS;
    cpu_busy = state != IDLE;
  end
  always_ff @(posedge pclk) begin
    if (rst) begin
      state <= IDLE;
      paddr <= '0;
      pdata <= '0;
      pwrite <= 1'b0;
      pstb <= '0;
      cpu_done <= 1'b0;
      cpu_rdata <= '0;
      cpu_err <= 1'b0;
    end else begin
      state <= state_n;
      cpu_done <= fin;
      if (state == IDLE && cpu_req) begin
        paddr <= cpu_addr;
        pdata <= cpu_we ? cpu_wdata : '0;
        pwrite <= cpu_we;
        pstb <= cpu_stb;
      end
      // A real ready wins over a timeout landing in the same cycle.
      if (fin) begin
        cpu_rdata <= (pwrite || !ready) ? '0 : prdata;
        cpu_err <= ready ? perr : 1'b1;
      end
    end
  end
endmodule
